// File: rtl/winner_select_window.sv
// winner_select_window: windowed spike counting, sequential argmax with valid/ready result, winner-gated spike output
module winner_select_window #(
  parameter int NUM_NODES = 10,
  parameter int CNT_W     = 16,
  parameter int WIN_LEN   = 64,
  localparam int IDX_W    = $clog2(NUM_NODES),
  localparam int STEP_W   = $clog2(WIN_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 step_i,
  input  logic [NUM_NODES-1:0] nodes_i,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 winner_valid_o,
  input  logic                 winner_ready_i,
  output logic [IDX_W-1:0]     winner_idx_o,
  output logic [CNT_W-1:0]     winner_cnt_o,
  output logic                 winner_none_o,
  output logic                 spike_o
);
  typedef enum logic [1:0] {COUNT, SCAN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0]  cnt [NUM_NODES];
  logic [STEP_W-1:0] step_cnt;
  logic [IDX_W-1:0]  scan_idx, best_idx, last_winner;
  logic [CNT_W-1:0]  best_cnt;
  logic              have_winner, last_step, last_scan;
  assign last_step = step_i && !clear_i && step_cnt == STEP_W'(WIN_LEN - 1);
  assign last_scan = scan_idx == IDX_W'(NUM_NODES - 1);
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= COUNT;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = (state == COUNT && last_step)      ? SCAN  :
               (state == SCAN  && last_scan)      ? DONE  :
               (state == DONE  && winner_ready_i) ? COUNT : state;
  end
  always_comb begin
    busy_o         = state != COUNT;
    winner_valid_o = state == DONE;
    winner_none_o  = state == DONE && best_cnt == '0;
    winner_idx_o   = best_idx;
    winner_cnt_o   = best_cnt;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_NODES; i++) cnt[i] <= '0;
      step_cnt    <= '0;
      scan_idx    <= '0;
      best_idx    <= '0;
      best_cnt    <= '0;
      last_winner <= '0;
      have_winner <= 1'b0;
      spike_o     <= 1'b0;
    end else begin
      // the gate uses the winner in force before any accept in this same cycle
      spike_o <= step_i && (have_winner ? nodes_i[last_winner] : |nodes_i);
      case (state)
        COUNT: begin
          if (clear_i) begin
            for (int i = 0; i < NUM_NODES; i++) cnt[i] <= '0;
            step_cnt <= '0;
          end else if (step_i) begin
            for (int i = 0; i < NUM_NODES; i++)
              cnt[i] <= &cnt[i] ? cnt[i] : cnt[i] + CNT_W'(nodes_i[i]);
            step_cnt <= last_step ? '0 : step_cnt + STEP_W'(1);
            if (last_step) begin
              scan_idx <= '0;
              best_idx <= '0;
              best_cnt <= '0;
            end
          end
        end
        SCAN: begin
          if (cnt[scan_idx] > best_cnt) begin
            best_cnt <= cnt[scan_idx];
            best_idx <= scan_idx;
          end
          scan_idx <= scan_idx + IDX_W'(1);
          if (last_scan)
            for (int i = 0; i < NUM_NODES; i++) cnt[i] <= '0;
        end
        DONE: begin
          if (winner_ready_i) begin
            last_winner <= best_idx;
            have_winner <= best_cnt != '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_winner_select_window.sv
// tb_winner_select_window: randomized windows checked against a count/argmax model of the winner stage
module tb_winner_select_window;
  localparam int N = 4, CW = 3, WL = 12, IW = 2;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, rst = 1, step = 0, clear = 0, ready = 0;
  logic [N-1:0] nodes = '0;
  logic busy, valid, none, spike;
  logic [IW-1:0] idx;
  logic [CW-1:0] wcnt;
  int total = 0, bad = 0;
  int raw [N];
  int have_w = 0, last_w = 0, e_idx = 0, e_cnt = 0;
  logic e_none = 0, e_spike = 0;

  winner_select_window #(.NUM_NODES(N), .CNT_W(CW), .WIN_LEN(WL)) dut (
    .clk_i(clk), .rst_i(rst), .step_i(step), .nodes_i(nodes), .clear_i(clear),
    .busy_o(busy), .winner_valid_o(valid), .winner_ready_i(ready),
    .winner_idx_o(idx), .winner_cnt_o(wcnt), .winner_none_o(none), .spike_o(spike)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    e_spike = !rst && step && (have_w != 0 ? nodes[last_w] : |nodes);
    @(posedge clk); #1;
    chk("spike", 32'(spike), 32'(e_spike));
  endtask

  task automatic predict();
    int mx = 0;
    for (int i = 0; i < N; i++) mx = (raw[i] > SAT ? SAT : raw[i]) > mx ? (raw[i] > SAT ? SAT : raw[i]) : mx;
    e_idx = 0;
    for (int i = N - 1; i >= 0; i--) if ((raw[i] > SAT ? SAT : raw[i]) == mx) e_idx = i;
    e_cnt = mx;
    e_none = mx == 0;
    if (e_none) e_idx = 0;
  endtask

  function automatic logic [N-1:0] pat_nodes(input int pat, input int s);
    case (pat)
      1: return 4'b0100 | (s < 3 ? 4'b0010 : 4'b0000);
      2: return (s < 5 ? 4'b1010 : 4'b0000) | (s < 2 ? 4'b0001 : 4'b0000);
      3: return 4'b0000;
      4: return 4'b0001;
      5: return N'($urandom & $urandom);
      default: return N'($urandom);
    endcase
  endfunction

  task automatic count_steps(input int pat, input int from, input int to);
    for (int s = from; s < to; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        step = 0; nodes = N'($urandom);
        tick();
        chk("busy_idle", 32'(busy), 32'(0));
      end
      step = 1; nodes = pat_nodes(pat, s);
      tick();
      for (int i = 0; i < N; i++) raw[i] += int'(nodes[i]);
      step = 0;
      if (s != WL - 1) begin
        chk("busy_count", 32'(busy), 32'(0));
        chk("valid_count", 32'(valid), 32'(0));
      end
    end
  endtask

  task automatic scan_check();
    for (int k = 1; k <= N; k++) begin
      step = 1'($urandom_range(0, 1)); nodes = N'($urandom);
      tick();
      chk("busy_scan", 32'(busy), 32'(1));
      chk("valid_latency", 32'(valid), 32'(k == N));
    end
    step = 0;
    predict();
    chk("idx", 32'(idx), 32'(e_idx));
    chk("cnt", 32'(wcnt), 32'(e_cnt));
    chk("none", 32'(none), 32'(e_none));
  endtask

  task automatic hold_accept(input int hold);
    for (int h = 0; h < hold; h++) begin
      ready = 0; step = 1'($urandom_range(0, 1)); nodes = N'($urandom);
      tick();
      chk("valid_hold", 32'(valid), 32'(1));
      chk("busy_hold", 32'(busy), 32'(1));
      chk("idx_hold", 32'(idx), 32'(e_idx));
      chk("cnt_hold", 32'(wcnt), 32'(e_cnt));
      chk("none_hold", 32'(none), 32'(e_none));
    end
    ready = 1; step = 1'($urandom_range(0, 1)); nodes = N'($urandom);
    tick();
    ready = 0; step = 0;
    have_w = e_none ? 0 : 1;
    last_w = e_idx;
    chk("valid_drop", 32'(valid), 32'(0));
    chk("busy_drop", 32'(busy), 32'(0));
    for (int i = 0; i < N; i++) raw[i] = 0;
  endtask

  task automatic run_window(input int pat, input int hold);
    count_steps(pat, 0, WL);
    scan_check();
    hold_accept(hold);
  endtask

  initial begin
    for (int i = 0; i < N; i++) raw[i] = 0;
    tick(); tick();
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_idx", 32'(idx), 32'(0));
    chk("rst_cnt", 32'(wcnt), 32'(0));
    chk("rst_none", 32'(none), 32'(0));
    rst = 0;
    run_window(3, 2);
    chk("no_winner", 32'(have_w), 32'(0));
    run_window(1, 10);
    chk("t1_idx", 32'(idx), 32'(2));
    step = 1; nodes = 4'b0110;
    tick();
    chk("gate_hit", 32'(spike), 32'(1));
    for (int i = 0; i < N; i++) raw[i] += int'(nodes[i]);
    nodes = 4'b0010;
    tick();
    chk("gate_miss", 32'(spike), 32'(0));
    for (int i = 0; i < N; i++) raw[i] += int'(nodes[i]);
    step = 0;
    count_steps(0, 2, 4);
    clear = 1; step = 1; nodes = N'($urandom);
    tick();
    clear = 0; step = 0;
    for (int i = 0; i < N; i++) raw[i] = 0;
    chk("clear_busy", 32'(busy), 32'(0));
    run_window(5, 1);
    run_window(2, 1);
    run_window(4, 0);
    for (int r = 0; r < 8; r++) run_window(r % 3 == 0 ? 0 : 5, int'($urandom_range(0, 4)));
    count_steps(5, 0, WL);
    for (int k = 0; k < 2; k++) begin
      step = 1'($urandom_range(0, 1)); nodes = N'($urandom);
      tick();
      chk("busy_pre_rst", 32'(busy), 32'(1));
    end
    rst = 1; step = 0;
    tick();
    rst = 0;
    have_w = 0; last_w = 0;
    for (int i = 0; i < N; i++) raw[i] = 0;
    chk("rst_scan_valid", 32'(valid), 32'(0));
    chk("rst_scan_busy", 32'(busy), 32'(0));
    run_window(5, 1);
    run_window(1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
